// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU command codes, op/state encodings and default width for alu_mseq.
package alu_pkg;
    localparam int DW = 8;
    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_LSH = 4'b0001;
    localparam logic [3:0] CMD_RSH = 4'b0010;
    localparam logic [3:0] CMD_NOP = 4'b1111;
    typedef enum logic [1:0] {OP_ADD16 = 2'b00, OP_SHL16 = 2'b01, OP_SHR16 = 2'b10, OP_MUL8 = 2'b11} op_t;
    typedef enum logic [2:0] {S_IDLE, S_STEP1, S_STEP2, S_MUL_ADD, S_MUL_SHF, S_DONE} state_t;
endpackage

// File: rtl/alu_mseq_if.sv
// alu_mseq_if: start/busy/done request bus between the core controller and alu_mseq.
interface alu_mseq_if #(parameter int DW = alu_pkg::DW);
    logic            start_i;
    logic [1:0]      op_i;
    logic [2*DW-1:0] a_i;
    logic [2*DW-1:0] b_i;
    logic            busy_o;
    logic            done_o;
    logic [2*DW-1:0] result_o;
    logic            carry_o;
    logic            zero_o;
    modport master (output start_i, op_i, a_i, b_i, input busy_o, done_o, result_o, carry_o, zero_o);
    modport slave  (input start_i, op_i, a_i, b_i, output busy_o, done_o, result_o, carry_o, zero_o);
endinterface

// File: rtl/alu_mseq.sv
// alu_mseq: runs 16-bit add/shift and 8x8 multiply as byte steps on the shared 8-bit ALU.
module alu_mseq #(
    parameter int DW        = 8,
    parameter int MUL_ITERS = DW
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_mseq_if.slave     bus,
    output logic          alu_en_o,
    output logic [3:0]    alu_cmd_o,
    output logic [DW-1:0] alu_a_o,
    output logic [DW-1:0] alu_b_o,
    output logic          alu_sci_o,
    input  logic [DW-1:0] alu_rslt_i,
    input  logic          alu_sco_i
);
    import alu_pkg::*;
    localparam int CW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
    state_t          state, state_n;
    op_t             op;
    logic [2*DW-1:0] a, b, result;
    logic [DW-1:0]   acc, acc_n, mpl, mpl_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            c, c_n, co, carry, zero, hi;
    // acc holds the high result byte and mpl the low byte for every op
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        mpl_n     = mpl;
        cnt_n     = cnt;
        c_n       = c;
        co        = 1'b0;
        hi        = 1'b0;
        alu_en_o  = 1'b0;
        alu_cmd_o = CMD_NOP;
        alu_a_o   = '0;
        alu_b_o   = '0;
        alu_sci_o = 1'b0;
        case (state)
            S_IDLE: if (bus.start_i) begin
                state_n = (op_t'(bus.op_i) == OP_MUL8) ? S_MUL_ADD : S_STEP1;
                acc_n   = '0;
                mpl_n   = bus.b_i[DW-1:0];
                cnt_n   = '0;
            end
            S_STEP1, S_STEP2: begin
                hi        = (state == S_STEP2) ^ (op == OP_SHR16);
                alu_en_o  = 1'b1;
                alu_cmd_o = (op == OP_ADD16) ? CMD_ADD : (op == OP_SHL16) ? CMD_LSH : CMD_RSH;
                alu_a_o   = hi ? a[2*DW-1:DW] : a[DW-1:0];
                alu_b_o   = (op != OP_ADD16) ? '0 : hi ? b[2*DW-1:DW] : b[DW-1:0];
                alu_sci_o = (state == S_STEP2) & c;
                acc_n     = hi ? alu_rslt_i : acc;
                mpl_n     = hi ? mpl : alu_rslt_i;
                c_n       = alu_sco_i;
                co        = alu_sco_i;
                state_n   = (state == S_STEP1) ? S_STEP2 : S_DONE;
            end
            S_MUL_ADD: begin
                alu_en_o  = 1'b1;
                alu_cmd_o = CMD_ADD;
                alu_a_o   = acc;
                alu_b_o   = mpl[0] ? a[DW-1:0] : '0;
                acc_n     = alu_rslt_i;
                c_n       = alu_sco_i;
                state_n   = S_MUL_SHF;
            end
            S_MUL_SHF: begin
                alu_en_o  = 1'b1;
                alu_cmd_o = CMD_RSH;
                alu_a_o   = acc;
                alu_sci_o = c;
                acc_n     = alu_rslt_i;
                mpl_n     = {alu_sco_i, mpl[DW-1:1]};
                cnt_n     = cnt + 1'b1;
                state_n   = (cnt == CW'(MUL_ITERS - 1)) ? S_DONE : S_MUL_ADD;
            end
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op     <= OP_ADD16;
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            mpl    <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            mpl   <= mpl_n;
            cnt   <= cnt_n;
            c     <= c_n;
            if (state == S_IDLE && bus.start_i) begin
                op <= op_t'(bus.op_i);
                a  <= bus.a_i;
                b  <= bus.b_i;
            end
            if (state_n == S_DONE) begin
                result <= {acc_n, mpl_n};
                carry  <= co;
                zero   <= ({acc_n, mpl_n} == '0);
            end
        end
    end
    assign bus.busy_o   = (state != S_IDLE);
    assign bus.done_o   = (state == S_DONE);
    assign bus.result_o = result;
    assign bus.carry_o  = carry;
    assign bus.zero_o   = zero;
endmodule

// File: tb/tb_alu_mseq.sv
// tb_alu_mseq: drives alu_mseq against a stand-in 8-bit ALU and checks it with an arithmetic reference model.
module tb_alu_mseq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alu_en, alu_sci, alu_sco;
    logic [3:0] alu_cmd;
    logic [7:0] alu_a, alu_b, alu_rslt;
    int         n_cmp = 0;
    int         n_bad = 0;
    alu_mseq_if #(.DW(8)) bus ();
    alu_mseq #(.DW(8), .MUL_ITERS(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_en_o(alu_en), .alu_cmd_o(alu_cmd), .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_sci_o(alu_sci), .alu_rslt_i(alu_rslt), .alu_sco_i(alu_sco)
    );
    always #5 clk = ~clk;
    // the shared core ALU this block borrows
    always_comb begin
        {alu_sco, alu_rslt} = 9'h0;
        case (alu_cmd)
            4'b0000: {alu_sco, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h0, alu_sci};
            4'b0001: {alu_sco, alu_rslt} = {alu_a, alu_sci};
            4'b0010: {alu_sco, alu_rslt} = {alu_a[0], alu_sci, alu_a[7:1]};
            default: {alu_sco, alu_rslt} = 9'h0;
        endcase
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [16:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        case (op)
            2'd0: r = {1'b0, a} + {1'b0, b};
            2'd1: r = {a[15], a[14:0], 1'b0};
            2'd2: r = {a[0], 1'b0, a[15:1]};
            default: r = {1'b0, 16'(a[7:0] * b[7:0])};
        endcase
        return r;
    endfunction
    // called one step after a rising edge with the block in IDLE; returns there, one cycle after DONE
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input bit hold);
        logic [16:0] exp;
        int cyc, lat;
        logic [3:0] ecmd;
        exp = model(op, a, b);
        lat = (op == 2'd3) ? 17 : 3;
        check("idle_busy", bus.busy_o, 1'b0);
        check("idle_alu", {alu_en, alu_cmd, alu_a, alu_b, alu_sci}, {1'b0, 4'hF, 17'h0});
        bus.start_i = 1'b1;
        bus.op_i = op;
        bus.a_i = a;
        bus.b_i = b;
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.start_i = hold;
            if (hold) begin
                bus.a_i = 16'($urandom);
                bus.b_i = 16'($urandom);
            end
            if (bus.done_o) break;
            ecmd = (op == 2'd3) ? ((cyc % 2 == 1) ? 4'h0 : 4'h2) : {2'b00, op};
            check("step_cmd", {alu_en, alu_cmd}, {1'b1, ecmd});
            if (cyc == 1 && op != 2'd3) check("step1_a", alu_a, (op == 2'd2) ? a[15:8] : a[7:0]);
        end
        check("latency", cyc, lat);
        check("result", bus.result_o, exp[15:0]);
        check("carry", bus.carry_o, exp[16]);
        check("zero", bus.zero_o, exp[15:0] == 16'h0);
        check("done_alu", {alu_en, alu_cmd, alu_a, alu_b, alu_sci}, {1'b0, 4'hF, 17'h0});
        @(posedge clk);
        #1;
        check("after_done", {bus.busy_o, bus.done_o}, 2'b00);
        check("hold", bus.result_o, exp[15:0]);
        bus.start_i = 1'b0;
    endtask
    initial begin
        bus.start_i = 1'b0;
        bus.op_i = 2'd0;
        bus.a_i = '0;
        bus.b_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", {bus.busy_o, bus.done_o, bus.result_o, bus.carry_o, bus.zero_o, alu_en, alu_cmd},
              {4'h0, 19'h0, 4'hF});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(2'd0, 16'h12FF, 16'h0001, 1'b0);
        run_op(2'd0, 16'hFFFF, 16'h0001, 1'b0);
        run_op(2'd1, 16'h8081, 16'h0000, 1'b0);
        run_op(2'd2, 16'h0101, 16'h0000, 1'b0);
        run_op(2'd3, 16'h00FF, 16'h00FF, 1'b0);
        run_op(2'd3, 16'h0000, 16'h005A, 1'b0);
        run_op(2'd3, 16'h000D, 16'h000B, 1'b0);
        run_op(2'd3, 16'h0037, 16'h00C3, 1'b1);
        run_op(2'd0, 16'h4321, 16'h8765, 1'b0);
        // abort a multiply part-way with an asynchronous reset
        bus.start_i = 1'b1;
        bus.op_i = 2'd3;
        bus.a_i = 16'h00AB;
        bus.b_i = 16'h00CD;
        repeat (7) begin
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out", {bus.busy_o, bus.done_o, bus.result_o, bus.carry_o, bus.zero_o, alu_en, alu_cmd},
              {4'h0, 19'h0, 4'hF});
        @(posedge clk);
        #1;
        check("abort_done", bus.done_o, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_idle", bus.done_o | bus.busy_o, 1'b0);
        run_op(2'd3, 16'h00AB, 16'h00CD, 1'b0);
        for (int i = 0; i < 30; i++)
            run_op(2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
